// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU subsystem: opcodes, instruction
// field positions and the default data-memory latency.
package cpu8_pkg;

    localparam int MEM_LATENCY_DEFAULT = 5;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 24;
    localparam int RD_LSB  = 16;
    localparam int OFF_MSB = 23;
    localparam int OFF_LSB = 16;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int REG_IDX_W = 3;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;

    // Branch offsets count instructions, so they are scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [7:0] off);
        return {{22{off[7]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/cpu8_subsystem_data_mem_ctrl.sv
// 256x8 data memory with a fixed access latency; raises done for one cycle
// after the access so the core can commit on the following edge.
module data_mem_ctrl
    import cpu8_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       read_i,
    input  logic       write_i,
    input  logic [7:0] address_i,
    input  logic [7:0] write_data_i,
    output logic [7:0] read_data_o,
    output logic       done_o
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    logic [7:0]    mem_q [0:255];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [7:0]    read_data_q;
    logic          access;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        access = 1'b0;
        if (done_q) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (read_i || write_i) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                access = 1'b1;
                done_d = 1'b1;
            end
        end
    end

    // NOTE: the array is reset on purpose: memory contents must read as zero after every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            done_q      <= 1'b0;
            read_data_q <= 8'h00;
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (access && write_i) begin
                mem_q[address_i] <= write_data_i;
            end
            if (access && read_i) begin
                read_data_q <= mem_q[address_i];
            end
        end
    end

    assign read_data_o = read_data_q;
    assign done_o      = done_q;

endmodule

// File: rtl/cpu8_subsystem.sv
// 8-bit single-issue core: decode, 8x8 register file, ALU and PC logic,
// stalling on loads/stores until the attached data memory completes.
module cpu8_subsystem
    import cpu8_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic        READ,
    output logic        WRITE,
    output logic [7:0]  ADDRESS,
    output logic [7:0]  WRITE_DATA,
    output logic [7:0]  READ_DATA,
    output logic        BUSYWAIT
);

    logic [31:0]          pc_q, pc_d, pc_plus4;
    logic [7:0]           regs_q [0:7];
    logic [7:0]           op, imm, offset;
    logic [REG_IDX_W-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [7:0]           rs1_val, rs2_val, sub_res;
    logic [7:0]           wr_data, mem_addr;
    logic                 wr_en, branch, mem_rd, mem_wr, mem_done;
    logic                 unused_rs1_hi;

    assign op      = INSTRUCTION[OP_MSB:OP_LSB];
    assign offset  = INSTRUCTION[OFF_MSB:OFF_LSB];
    assign imm     = INSTRUCTION[IMM_MSB:IMM_LSB];
    assign rd_idx  = INSTRUCTION[RD_LSB  +: REG_IDX_W];
    assign rs1_idx = INSTRUCTION[RS1_LSB +: REG_IDX_W];
    assign rs2_idx = INSTRUCTION[RS2_LSB +: REG_IDX_W];
    assign unused_rs1_hi = ^INSTRUCTION[15:11];

    assign rs1_val = regs_q[rs1_idx];
    assign rs2_val = regs_q[rs2_idx];
    assign sub_res = rs1_val - rs2_val;

    always_comb begin
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        branch   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = 8'h00;
        case (op)
            OP_LOADI: begin wr_en = 1'b1; wr_data = imm;               end
            OP_MOV:   begin wr_en = 1'b1; wr_data = rs2_val;           end
            OP_ADD:   begin wr_en = 1'b1; wr_data = rs1_val + rs2_val; end
            OP_SUB:   begin wr_en = 1'b1; wr_data = sub_res;           end
            OP_AND:   begin wr_en = 1'b1; wr_data = rs1_val & rs2_val; end
            OP_OR:    begin wr_en = 1'b1; wr_data = rs1_val | rs2_val; end
            OP_J:     branch = 1'b1;
            OP_BEQ:   branch = (sub_res == 8'h00);
            OP_LWD:   begin mem_rd = 1'b1; mem_addr = rs2_val; wr_en = 1'b1; wr_data = READ_DATA; end
            OP_LWI:   begin mem_rd = 1'b1; mem_addr = imm;     wr_en = 1'b1; wr_data = READ_DATA; end
            OP_SWD:   begin mem_wr = 1'b1; mem_addr = rs2_val; end
            OP_SWI:   begin mem_wr = 1'b1; mem_addr = imm;     end
            default:  ;
        endcase
    end

    // Requests are masked during reset so the bus reads idle regardless of INSTRUCTION.
    assign READ       = mem_rd & RESET;
    assign WRITE      = mem_wr & RESET;
    assign ADDRESS    = mem_addr;
    assign WRITE_DATA = rs1_val;
    assign BUSYWAIT   = (READ | WRITE) & ~mem_done;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (BUSYWAIT) begin
            pc_d = pc_q;
        end else if (branch) begin
            pc_d = pc_plus4 + branch_offset(offset);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= 32'h0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            pc_q <= pc_d;
            if (wr_en && !BUSYWAIT) begin
                regs_q[rd_idx] <= wr_data;
            end
        end
    end

    assign PC = pc_q;

    data_mem_ctrl #(
        .LATENCY (MEM_LATENCY)
    ) u_data_mem_ctrl (
        .clk          (CLK),
        .rst_n        (RESET),
        .read_i       (READ),
        .write_i      (WRITE),
        .address_i    (ADDRESS),
        .write_data_i (WRITE_DATA),
        .read_data_o  (READ_DATA),
        .done_o       (mem_done)
    );

endmodule

// File: tb/tb_cpu8_subsystem.sv
// Directed self-checking bench for cpu8_subsystem; the program is served
// from a small instruction table indexed by PC.
module tb_cpu8_subsystem;
    import cpu8_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        READ, WRITE, BUSYWAIT;
    logic [7:0]  ADDRESS, WRITE_DATA, READ_DATA;

    logic [31:0] prog [0:63];
    int pass_cnt = 0;
    int total_cnt = 0;

    cpu8_subsystem #(.MEM_LATENCY(5)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .READ        (READ),
        .WRITE       (WRITE),
        .ADDRESS     (ADDRESS),
        .WRITE_DATA  (WRITE_DATA),
        .READ_DATA   (READ_DATA),
        .BUSYWAIT    (BUSYWAIT)
    );

    assign INSTRUCTION = prog[PC[7:2]];
    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        return {op, a, b, c};
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Enters reset and fills the program table with NOPs; caller loads code then releases.
    task automatic enter_reset();
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 32'hFF00_0000;
        repeat (2) @(negedge CLK);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Counts cycles spent at the current PC and how many of them had BUSYWAIT high.
    task automatic count_stall(output int cycles, output int busy);
        logic [31:0] pc0;
        pc0 = PC;
        cycles = 0;
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            if (BUSYWAIT) busy++;
            cycles++;
            step();
            if (PC !== pc0) break;
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        enter_reset();
        chk32("rst_pc", PC, 32'h0);
        chk32("rst_read", {31'h0, READ}, 32'h0);
        chk32("rst_write", {31'h0, WRITE}, 32'h0);
        chk32("rst_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk32("rst_rdata", {24'h0, READ_DATA}, 32'h0);
    endtask

    task automatic test_add_store();
        int cyc, bsy;
        enter_reset();
        prog[0] = enc(OP_LOADI, 8'd4, 8'd0, 8'd5);
        prog[1] = enc(OP_LOADI, 8'd2, 8'd0, 8'd9);
        prog[2] = enc(OP_ADD,   8'd6, 8'd4, 8'd2);
        prog[3] = enc(OP_SWI,   8'd0, 8'd6, 8'h10);
        release_reset();
        chk32("t1_pc0", PC, 32'd0);
        step(); chk32("t1_pc4", PC, 32'd4);
        step(); chk32("t1_pc8", PC, 32'd8);
        step(); chk32("t1_pc12", PC, 32'd12);
        chk32("t1_write", {31'h0, WRITE}, 32'h1);
        chk32("t1_read", {31'h0, READ}, 32'h0);
        chk32("t1_addr", {24'h0, ADDRESS}, 32'h10);
        chk32("t1_wdata", {24'h0, WRITE_DATA}, 32'h0E);
        chk32("t1_busy", {31'h0, BUSYWAIT}, 32'h1);
        count_stall(cyc, bsy);
        chk32("t1_stall_cycles", cyc, 32'd6);
        chk32("t1_busy_cycles", bsy, 32'd5);
        chk32("t1_pc16", PC, 32'd16);
    endtask

    task automatic test_logic_ops();
        int cyc, bsy;
        enter_reset();
        prog[0] = enc(OP_LOADI, 8'd1, 8'd0, 8'd3);
        prog[1] = enc(OP_LOADI, 8'd2, 8'd0, 8'd5);
        prog[2] = enc(OP_SUB,   8'd3, 8'd1, 8'd2);
        prog[3] = enc(OP_AND,   8'd4, 8'd1, 8'd2);
        prog[4] = enc(OP_OR,    8'd5, 8'd1, 8'd2);
        prog[5] = enc(OP_SWI,   8'd0, 8'd3, 8'h30);
        prog[6] = enc(OP_SWI,   8'd0, 8'd4, 8'h31);
        prog[7] = enc(OP_SWI,   8'd0, 8'd5, 8'h32);
        release_reset();
        repeat (5) step();
        chk32("t2_pc20", PC, 32'd20);
        chk32("t2_sub", {24'h0, WRITE_DATA}, 32'hFE);
        chk32("t2_addr", {24'h0, ADDRESS}, 32'h30);
        count_stall(cyc, bsy);
        chk32("t2_pc24", PC, 32'd24);
        chk32("t2_and", {24'h0, WRITE_DATA}, 32'h01);
        count_stall(cyc, bsy);
        chk32("t2_or", {24'h0, WRITE_DATA}, 32'h07);
        count_stall(cyc, bsy);
        chk32("t2_pc32", PC, 32'd32);
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [0:6];
        exp_pc = '{32'd0, 32'd4, 32'd8, 32'd16, 32'd20, 32'd16, 32'd20};
        enter_reset();
        prog[0] = enc(OP_LOADI, 8'd1, 8'd0, 8'd7);
        prog[1] = enc(OP_LOADI, 8'd2, 8'd0, 8'd7);
        prog[2] = enc(OP_BEQ,   8'd1, 8'd1, 8'd2);
        prog[3] = enc(OP_LOADI, 8'd3, 8'd0, 8'hAA);
        prog[4] = enc(OP_BEQ,   8'd3, 8'd1, 8'd3);
        prog[5] = enc(OP_J,     8'hFE, 8'd0, 8'd0);
        release_reset();
        for (int i = 0; i < 7; i++) begin
            total_cnt++;
            if (PC !== exp_pc[i]) $display("FAIL t3_pc_step%0d: got %0h expected %0h", i, PC, exp_pc[i]);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_load_store();
        int cyc, bsy;
        enter_reset();
        prog[0]  = enc(OP_LOADI, 8'd6, 8'd0, 8'h0E);
        prog[1]  = enc(OP_SWI,   8'd0, 8'd6, 8'h20);
        prog[2]  = enc(OP_LWI,   8'd7, 8'd0, 8'h20);
        prog[3]  = enc(OP_SWI,   8'd0, 8'd7, 8'h21);
        prog[4]  = enc(OP_LWI,   8'd0, 8'd0, 8'h21);
        release_reset();
        step();
        chk32("t4_st_pc", PC, 32'd4);
        count_stall(cyc, bsy);
        chk32("t4_st_cycles", cyc, 32'd6);
        chk32("t4_ld_pc", PC, 32'd8);
        chk32("t4_ld_read", {31'h0, READ}, 32'h1);
        chk32("t4_ld_write", {31'h0, WRITE}, 32'h0);
        chk32("t4_ld_addr", {24'h0, ADDRESS}, 32'h20);
        count_stall(cyc, bsy);
        chk32("t4_ld_cycles", cyc, 32'd6);
        chk32("t4_ld_busy", bsy, 32'd5);
        chk32("t4_ld_data", {24'h0, READ_DATA}, 32'h0E);
        chk32("t4_st2_wdata", {24'h0, WRITE_DATA}, 32'h0E);
        count_stall(cyc, bsy);
        chk32("t4_st2_cycles", cyc, 32'd6);
        count_stall(cyc, bsy);
        chk32("t4_ld2_data", {24'h0, READ_DATA}, 32'h0E);
        chk32("t4_pc20", PC, 32'd20);
    endtask

    task automatic test_back_to_back();
        int cyc, bsy;
        enter_reset();
        prog[0]  = enc(OP_LOADI, 8'd3, 8'd0, 8'h50);
        prog[1]  = enc(OP_LOADI, 8'd5, 8'd0, 8'hC3);
        prog[2]  = enc(OP_SWD,   8'd0, 8'd5, 8'd3);
        prog[3]  = enc(OP_LWD,   8'd2, 8'd0, 8'd3);
        prog[4]  = enc(OP_MOV,   8'd1, 8'd0, 8'd2);
        prog[5]  = enc(OP_SWI,   8'd0, 8'd1, 8'h51);
        release_reset();
        repeat (2) step();
        chk32("t6_swd_addr", {24'h0, ADDRESS}, 32'h50);
        chk32("t6_swd_wdata", {24'h0, WRITE_DATA}, 32'hC3);
        count_stall(cyc, bsy);
        chk32("t6_swd_cycles", cyc, 32'd6);
        chk32("t6_lwd_read", {31'h0, READ}, 32'h1);
        count_stall(cyc, bsy);
        chk32("t6_lwd_cycles", cyc, 32'd6);
        chk32("t6_lwd_data", {24'h0, READ_DATA}, 32'hC3);
        step();
        chk32("t6_mov_pc", PC, 32'd20);
        chk32("t6_mov_wdata", {24'h0, WRITE_DATA}, 32'hC3);
    endtask

    task automatic test_reset_mid_access();
        int cyc, bsy;
        enter_reset();
        prog[0] = enc(OP_LOADI, 8'd6, 8'd0, 8'h5A);
        prog[1] = enc(OP_SWI,   8'd0, 8'd6, 8'h40);
        release_reset();
        step();
        step();
        step();
        chk32("t5_pre_pc", PC, 32'd4);
        chk32("t5_pre_busy", {31'h0, BUSYWAIT}, 32'h1);
        #2 RESET = 1'b0;
        #1;
        chk32("t5_rst_pc", PC, 32'd0);
        chk32("t5_rst_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk32("t5_rst_write", {31'h0, WRITE}, 32'h0);
        for (int i = 0; i < 64; i++) prog[i] = 32'hFF00_0000;
        prog[0] = enc(OP_LOADI, 8'd2, 8'd0, 8'h33);
        prog[1] = enc(OP_SWI,   8'd0, 8'd2, 8'h41);
        prog[2] = enc(OP_LWI,   8'd1, 8'd0, 8'h41);
        prog[3] = enc(OP_LWI,   8'd1, 8'd0, 8'h40);
        repeat (2) @(negedge CLK);
        release_reset();
        step();
        count_stall(cyc, bsy);
        count_stall(cyc, bsy);
        chk32("t5_ld41_data", {24'h0, READ_DATA}, 32'h33);
        chk32("t5_ld40_addr", {24'h0, ADDRESS}, 32'h40);
        count_stall(cyc, bsy);
        chk32("t5_ld40_data", {24'h0, READ_DATA}, 32'h00);
        chk32("t5_pc16", PC, 32'd16);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 32'hFF00_0000;
        test_reset();
        test_add_store();
        test_logic_ops();
        test_branch();
        test_load_store();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
